// File: rtl/fp_mul_unit_pkg.sv
// fp_mul_unit_pkg
//   Shared definitions for the single-precision multiplier and its requester
//   (the matrix controller). It holds the FSM state encoding, the exponent bias,
//   the canonical NaN, the signed infinity/zero constants and the datapath widths.
package fp_mul_unit_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } fp_state_e;

  localparam int                 MANT_W       = 24;
  localparam int                 PROD_W       = 48;
  localparam logic signed [9:0]  BIAS         = 10'sd127;
  localparam logic signed [9:0]  EXP_OVF      = 10'sd255;
  localparam logic [7:0]         EXP_ALL_ONES = 8'hFF;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

  function automatic logic [31:0] signed_inf(input logic sign);
    return sign ? NEG_INF : POS_INF;
  endfunction

  function automatic logic [31:0] signed_zero(input logic sign);
    return sign ? NEG_ZERO : POS_ZERO;
  endfunction

endpackage

// File: rtl/fp_mul_unit_if.sv
// fp_mul_unit_if
//   Request/response handshake between the matrix controller (master) and the
//   multiplier (slave).
//   in_valid/in_ready : operand transfer, op_a * op_b
//   out_valid/out_ready : result transfer
interface fp_mul_unit_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/fp_mul_unit_mant_mul_seq.sv
// mant_mul_seq
//   Radix-2 shift-add mantissa multiplier, 24x24 -> 48, one bit per cycle.
//   clk, reset : clock, async active-low reset
//   start      : load operands; iterations run on the following ITERS edges
//   mcand      : multiplicand mantissa (hidden bit included)
//   mplier     : multiplier mantissa (hidden bit included)
//   done       : high during the cycle whose closing edge performs the final
//                iteration; product is complete right after that edge
//   product    : accumulated 48-bit product
module mant_mul_seq
  import fp_mul_unit_pkg::*;
#(
  parameter int ITERS = MANT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MANT_W-1:0] mcand,
  input  logic [MANT_W-1:0] mplier,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] mcand_q;
  logic [MANT_W-1:0] mplier_q;
  logic [4:0]        cnt_q;
  logic              busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{(PROD_W-MANT_W){1'b0}}, mcand};
      mplier_q <= mplier;
      cnt_q    <= 5'(ITERS - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 5'd1;
      if (cnt_q == 5'd0) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done    = busy_q && (cnt_q == 5'd0);
  assign product = acc_q;

endmodule

// File: rtl/fp_mul_unit.sv
// fp_mul_unit
//   Sequential IEEE-754 single-precision multiplier, one operation in flight,
//   fixed latency of 27 cycles from the accept edge to out_valid for every
//   operand class. Denormal inputs flush to zero; no denormal outputs.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of fp_mul_unit_if (operands in, result out)
//
//   state  | meaning
//   IDLE   | in_ready=1, operands captured on in_valid
//   UNPACK | classify operands, form sign/exponent, start mantissa multiply
//   MULT   | 24 shift-add iterations
//   NORM   | align product, extract guard/sticky
//   ROUND  | round-to-nearest-even, pack or select special, load result
//   DONE   | out_valid=1 until out_ready
module fp_mul_unit
  import fp_mul_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 27
) (
  input logic          clk,
  input logic          reset,
  fp_mul_unit_if.slave bus
);

  // Unpack, normalize and round each take one cycle around the multiply.
  localparam int MUL_ITERS = LATENCY - 3;

  fp_state_e state_q, state_d;
  logic      in_ready_c, out_valid_c, mul_start_c;

  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, result_q, spec_result_q;
  logic                  sign_q, spec_q;
  logic signed [9:0]     exp_q;
  logic [MANT_W-1:0]     mant_q;
  logic                  guard_q, sticky_q;

  logic              mul_done;
  logic [PROD_W-1:0] mul_prod;

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    mul_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = UNPACK;
      end
      UNPACK: begin
        mul_start_c = 1'b1;
        state_d     = MULT;
      end
      MULT:  if (mul_done) state_d = NORM;
      NORM:  state_d = ROUND;
      ROUND: state_d = DONE;
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;

  // Operand classification
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign_c, spec_c;
  logic [DATA_WIDTH-1:0] spec_val_c;

  assign ea = op_a_q[30:23];
  assign eb = op_b_q[30:23];
  assign fa = op_a_q[22:0];
  assign fb = op_b_q[22:0];

  // Exponent zero covers both true zero and denormals (flushed).
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == EXP_ALL_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ALL_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ALL_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ALL_ONES) && (fb != '0);
  assign sign_c = op_a_q[31] ^ op_b_q[31];

  always_comb begin
    spec_c     = 1'b1;
    spec_val_c = QNAN;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_val_c = QNAN;
    end else if (a_inf || b_inf) begin
      spec_val_c = signed_inf(sign_c);
    end else if (a_zero || b_zero) begin
      spec_val_c = signed_zero(sign_c);
    end else begin
      spec_c     = 1'b0;
      spec_val_c = '0;
    end
  end

  // Rounding and packing
  logic              round_up;
  logic [MANT_W:0]   mant_sum;
  logic [22:0]       frac_rnd;
  logic signed [9:0] exp_rnd;
  logic [DATA_WIDTH-1:0] packed_c;

  always_comb begin
    round_up = guard_q & (sticky_q | mant_q[0]);
    mant_sum = {1'b0, mant_q} + {{MANT_W{1'b0}}, round_up};
    // A carry out of the mantissa leaves 1.000..0, one binade up.
    if (mant_sum[MANT_W]) begin
      frac_rnd = mant_sum[23:1];
      exp_rnd  = exp_q + 10'sd1;
    end else begin
      frac_rnd = mant_sum[22:0];
      exp_rnd  = exp_q;
    end
    if (spec_q) begin
      packed_c = spec_result_q;
    end else if (exp_rnd >= EXP_OVF) begin
      packed_c = signed_inf(sign_q);
    end else if (exp_rnd <= 10'sd0) begin
      packed_c = signed_zero(sign_q);
    end else begin
      packed_c = {sign_q, exp_rnd[7:0], frac_rnd};
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q        <= '0;
      op_b_q        <= '0;
      result_q      <= '0;
      spec_result_q <= '0;
      sign_q        <= 1'b0;
      spec_q        <= 1'b0;
      exp_q         <= '0;
      mant_q        <= '0;
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_a_q <= bus.op_a;
            op_b_q <= bus.op_b;
          end
        end
        UNPACK: begin
          sign_q        <= sign_c;
          spec_q        <= spec_c;
          spec_result_q <= spec_val_c;
          exp_q         <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        end
        NORM: begin
          if (mul_prod[47]) begin
            mant_q   <= mul_prod[47:24];
            guard_q  <= mul_prod[23];
            sticky_q <= |mul_prod[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            mant_q   <= mul_prod[46:23];
            guard_q  <= mul_prod[22];
            sticky_q <= |mul_prod[21:0];
          end
        end
        ROUND: result_q <= packed_c;
        default: ;
      endcase
    end
  end

  mant_mul_seq #(
    .ITERS(MUL_ITERS)
  ) u_mant_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start_c),
    .mcand  ({1'b1, fa}),
    .mplier ({1'b1, fb}),
    .done   (mul_done),
    .product(mul_prod)
  );

endmodule

// File: tb/tb_fp_mul_unit.sv
// tb_fp_mul_unit
//   Directed vectors with hand-computed products, latency, DONE hold,
//   and mid-operation reset.
module tb_fp_mul_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fp_mul_unit_if bus();

  fp_mul_unit #(
    .DATA_WIDTH(32),
    .LATENCY   (27)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t vecs [17] = '{
    '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000},
    '{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000},
    '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000},
    '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002},
    '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000},
    '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000},
    '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000},
    '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000},
    '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000},
    '{32'h0000_0001, 32'hC000_0000, 32'h8000_0000},
    '{32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002},
    '{32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004},
    '{32'h3FFF_FFFE, 32'h3F80_0001, 32'h4000_0000},
    '{32'h2000_0000, 32'h1F80_0000, 32'h0000_0000},
    '{32'h2000_0000, 32'h2000_0000, 32'h0080_0000},
    '{32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000},
    '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000}
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp);
    int cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk({tag, "_lat"}, 32'(cycles), 32'd27);
    chk({tag, "_res"}, bus.result, exp);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ov_after"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_ir_after"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;

    #12;
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result",    bus.result,             32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_result($sformatf("vec%0d", i), vecs[i].e);
      release_result($sformatf("vec%0d", i));
    end

    // Hold in DONE with out_ready low; an in_valid pulse must be ignored.
    launch(32'h3FC0_0000, 32'h3FC0_0000);
    wait_result("hold", 32'h4010_0000);
    repeat (4) begin @(posedge clk); #1; end
    bus.op_a     = 32'h4000_0000;
    bus.op_b     = 32'h4000_0000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("hold_result",    bus.result,             32'h4010_0000);
    chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("hold_in_ready",  {31'd0, bus.in_ready},  32'd0);
    release_result("hold");
    launch(32'h4000_0000, 32'h4040_0000);
    wait_result("post_hold", 32'h40C0_0000);
    release_result("post_hold");

    // Reset 10 cycles into an operation; it must be abandoned.
    launch(32'h4000_0000, 32'h4040_0000);
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_result",    bus.result,             32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    launch(32'h3F80_0000, 32'h3F80_0000);
    wait_result("after_rst", 32'h3F80_0000);
    release_result("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_unit.md
FP_MUL_UNIT -- requirements
Module: fp_mul_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; only 32 (IEEE-754 single) is supported.
REQ-002 SHALL have parameter LATENCY, default 27, informational cycles from accept edge to out_valid; not to be overridden.
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  requester presents operands.
REQ-007 in_ready  output  1  unit can accept operands.
REQ-008 op_a  input  32  multiplicand, IEEE-754 single.
REQ-009 op_b  input  32  multiplier, IEEE-754 single.
REQ-010 out_valid  output  1  result is valid.
REQ-011 out_ready  input  1  requester consumes result.
REQ-012 result  output  32  product, IEEE-754 single.

Function
REQ-013 SHALL be the responder for the matrix controller's send-to-multiply / wait-for-result handshake; one operation in flight.
REQ-014 SHALL implement states IDLE, UNPACK, MULT, NORM, ROUND, DONE.
REQ-015 IDLE: in_ready=1; op_a/op_b registered on a clk edge with in_valid&&in_ready; next state UNPACK.
REQ-016 UNPACK: split sign/exponent/mantissa, add hidden bit, classify zero/inf/NaN/denormal; next MULT.
REQ-017 MULT: radix-2 shift-add over 24 mantissa bits, 5-bit counter, exactly 24 cycles, 48-bit product; then NORM.
REQ-018 NORM: if product bit 47 set, shift right 1 and increment exponent; form guard and sticky bits; next ROUND.
REQ-019 ROUND: round-to-nearest-even; mantissa carry-out renormalizes; next DONE.
REQ-020 Exponent math SHALL use 10-bit signed: ea+eb-127(+1 on normalize); no 8-bit wraparound.
REQ-021 DONE: out_valid=1, result stable; on out_ready=1 return to IDLE; out_ready=0 holds indefinitely.
REQ-022 out_valid SHALL rise exactly 27 cycles after the accept edge, identical for special cases (fixed latency).
REQ-023 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE is ignored.
REQ-024 Result sign SHALL equal sign_a XOR sign_b for all non-NaN outputs.
REQ-025 Either operand NaN, or inf x zero, SHALL give 0x7FC00000.
REQ-026 Inf x nonzero SHALL give signed infinity.
REQ-027 Denormal inputs SHALL be treated as zero (flush); zero x finite gives signed zero.
REQ-028 Biased exponent >=255 after rounding SHALL give signed infinity.
REQ-029 Biased exponent <=0 SHALL give signed zero (no denormal output).
REQ-030 result SHALL change only on the DONE-entry edge.

Reset
REQ-031 reset low SHALL force IDLE asynchronously: in_ready=1, out_valid=0, result=0, counter=0, internal registers cleared.
REQ-032 reset mid-operation SHALL abandon the operation; no out_valid pulse for it after release.
REQ-033 The first in_valid edge after reset release SHALL be accepted.

Structure
REQ-034 State encodings (3-bit), BIAS=127, QNAN=32'h7FC00000, and the special-value constants SHALL live in a shared package, also used by the matrix controller.
REQ-035 The 24-iteration shift-add datapath SHALL be one sub-module, mant_mul_seq (start, done, 24x24->48).

Verification
REQ-036 0x40000000 x 0x40400000 (2.0x3.0) -> result 0x40C00000, out_valid exactly 27 cycles after accept.
REQ-037 0xC0000000 x 0x40400000 -> 0xC0C00000; 0x3FC00000 x 0x3FC00000 -> 0x40100000 (normalize path).
REQ-038 0x3F800001 x 0x3F800001 -> 0x3F800002 (round-to-nearest-even, sticky set).
REQ-039 0x7F800000 x 0x00000000 -> 0x7FC00000; 0x7F000000 x 0x7F000000 -> 0x7F800000; 0x00800000 x 0x00800000 -> 0x00000000.
REQ-040 out_ready held 0 for 10 cycles in DONE -> result/out_valid stable, in_ready 0; in_valid pulse meanwhile ignored.
REQ-041 reset asserted 10 cycles after accept -> in_ready=1, out_valid=0 immediately; new op 1.0x1.0 -> 0x3F800000 at 27 cycles.
